// File: rtl/sll32_seq.sv
// Sequential 32-bit logical shift-left: one bit per cycle, IDLE/SHIFT/DONE control.
// Define SLL32_SEQ_VAR_EN to add var_sel (variable shift amount taken from B[4:0]).
module sll32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef SLL32_SEQ_VAR_EN
  input  logic        var_sel,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] res,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] res_reg, res_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [4:0]  shamt;
  logic        accept;

`ifdef SLL32_SEQ_VAR_EN
  assign shamt = var_sel ? B[4:0] : B[10:6];
`else
  assign shamt = B[10:6];
`endif

  // Instruction bits outside the shift-amount fields are intentionally ignored
  logic unused_b;
  assign unused_b = ^{B[31:11], B[5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        busy     = 1'b1;
        acc_next = {acc_reg[30:0], 1'b0};
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          res_next   = {acc_reg[30:0], 1'b0};
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        accept     = start;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A zero shift completes on the accepting edge itself
    if (accept) begin
      acc_next = A;
      cnt_next = shamt;
      if (shamt == 5'd0) begin
        res_next   = A;
        state_next = DONE;
      end else begin
        state_next = SHIFT;
      end
    end
  end

  assign res = res_reg;

endmodule

// File: tb/tb_sll32_seq.sv
// Directed self-checking bench for sll32_seq: latency, busy/done timing, hold, reset abort.
module tb_sll32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        var_sel;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] res;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int done_count;

  sll32_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef SLL32_SEQ_VAR_EN
    .var_sel(var_sel),
`endif
    .A      (A),
    .B      (B),
    .res    (res),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request; caller is positioned at a falling edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Wait for completion, checking latency n+1, n busy cycles, res held, and final result
  task automatic finish(input int n, input logic [31:0] exp, input int poke, input string tag);
    int          cyc;
    int          nbusy;
    bit          seen;
    logic [31:0] held;
    held  = res;
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        start = 1'b1;
        A     = 32'h0000_0005;
        B     = 32'h0000_0080;
      end else if (poke != 0 && i == poke + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end else begin
        if (busy) nbusy++;
        chk({tag, "/hold"}, res, held);
      end
    end
    chk({tag, "/done_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(cyc), 32'(n + 1));
    chk({tag, "/busy_cycles"}, 32'(nbusy), 32'(n));
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "/res"}, res, exp);
    $display("op %s: n=%0d latency=%0d busy_cycles=%0d res=%h", tag, n, cyc, nbusy, res);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    var_sel = 1'b0;
    A       = '0;
    B       = '0;

    #2;
    chk("reset/res", res, 32'h0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done", 32'(done), 32'd0);

    // start while in reset must be ignored
    start = 1'b1;
    A     = 32'h0000_0001;
    B     = 32'h0000_0040;
    @(posedge clk);
    @(negedge clk);
    chk("reset_start/busy", 32'(busy), 32'd0);
    chk("reset_start/done", 32'(done), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    issue(32'h0000_0001, 32'(4) << 6);
    finish(4, 32'h0000_0010, 0, "sll4");
    @(negedge clk);
    chk("sll4/done_one_cycle", 32'(done), 32'd0);
    chk("sll4/idle_busy", 32'(busy), 32'd0);
    chk("sll4/idle_hold", res, 32'h0000_0010);

    issue(32'hDEAD_BEEF, 32'h0);
    finish(0, 32'hDEAD_BEEF, 0, "sll0");
    @(negedge clk);
    chk("sll0/done_one_cycle", 32'(done), 32'd0);

    issue(32'hFFFF_FFFF, 32'(31) << 6);
    finish(31, 32'h8000_0000, 10, "sll31_poke");
    @(negedge clk);
    chk("sll31_poke/idle", 32'(done | busy), 32'd0);

    issue(32'h1234_5678, (32'(16) << 6) | 32'hFFFF_F83F);
    finish(16, 32'h5678_0000, 0, "sll16_junkB");
    @(negedge clk);

    // back-to-back: second request raised while in DONE
    issue(32'h0000_00FF, 32'(8) << 6);
    finish(8, 32'h0000_FF00, 0, "b2b_op1");
    issue(32'h0000_0001, 32'(1) << 6);
    finish(1, 32'h0000_0002, 0, "b2b_op2");
    @(negedge clk);
    chk("b2b/done_one_cycle", 32'(done), 32'd0);

    // reset mid-shift aborts with no done pulse
    issue(32'h0000_0001, 32'(20) << 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/done", 32'(done), 32'd0);
    chk("abort/res", res, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    done_count = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    chk("abort/no_done", 32'(done_count), 32'd0);
    chk("abort/res_after", res, 32'h0);
    $display("op abort: done pulses after reset=%0d res=%h", done_count, res);

    issue(32'h0000_0003, 32'(5) << 6);
    finish(5, 32'h0000_0060, 0, "post_reset");
    @(negedge clk);

`ifdef SLL32_SEQ_VAR_EN
    var_sel = 1'b1;
    issue(32'h0000_0001, 32'h0000_0003);
    finish(3, 32'h0000_0008, 0, "sllv3");
    @(negedge clk);
    var_sel = 1'b0;
    issue(32'h0000_0001, 32'h0000_0003);
    finish(0, 32'h0000_0001, 0, "sll_varsel0");
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sll32_seq.md
SLL32_SEQ -- requirements
Module: sll32_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the shift-amount width at 5 bits.
REQ-002 clk  input  1  Single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  Reset; asynchronous, active-low.
REQ-004 start  input  1  Request; sampled on each rising edge of clk.
REQ-005 A  input  32  Operand to be shifted; captured when start is accepted.
REQ-006 B  input  32  Instruction word; B[10:6] is the shamt field, captured when start is accepted.
REQ-007 res  output  32  Registered result, A logically shifted left by the captured shift amount.
REQ-008 busy  output  1  High while a shift is in progress.
REQ-009 done  output  1  One-cycle pulse marking res as newly valid.

Function
REQ-010 The block SHALL implement a three-state machine with states IDLE, SHIFT and DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE, and SHALL be ignored in SHIFT.
- No queueing: an ignored start is lost.
REQ-012 On accepting start, the block SHALL perform all of the following:
- load acc <= A and cnt <= n, where n = captured shamt;
- if n = 0: load res <= A and go to DONE;
- otherwise: go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL do acc <= {acc[30:0],1'b0} and cnt <= cnt-1, with zero fill from the LSB.
REQ-014 In SHIFT with cnt = 1, the same edge SHALL load res <= {acc[30:0],1'b0} and go to DONE.
REQ-015 Latency from the accepting edge to done high SHALL be n+1 cycles, for n in 0..31.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE.
REQ-017 busy SHALL be high exactly while in SHIFT; busy and done SHALL never be high together.
REQ-018 In DONE: with start high, the block SHALL accept start per REQ-012 (back-to-back operation); otherwise it SHALL go to IDLE.
REQ-019 res SHALL change only on the edge entering DONE, and SHALL otherwise hold its last value, including in IDLE and throughout SHIFT.
REQ-020 Changes on A and B after acceptance SHALL have no effect on the operation in progress.
REQ-021 n = 31 SHALL produce res = {A[0],31'b0} after 31 shift cycles; no shift amount SHALL produce X or wrap-around.
REQ-022 res SHALL be bit-exact to the combinational result A << n for all A and n.

Reset
REQ-023 rst_n low SHALL immediately force the following, independent of clk:
- state = IDLE;
- acc = 0, cnt = 0, res = 0;
- busy = 0, done = 0.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse.
- The first start accepted after rst_n rises SHALL behave as from power-up.
REQ-025 While rst_n is low, start SHALL be ignored.

Configuration
REQ-026 Macro SLL32_SEQ_VAR_EN SHALL control variable-shift support.
- Defined: adds input port var_sel (1 bit, after start); captured n = var_sel ? B[4:0] : B[10:6] (sllv/sll).
- Undefined: var_sel is absent and n = B[10:6] always.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-027 A=32'h0000_0001, B[10:6]=4, start pulse -> busy high 4 cycles, done high at cycle 5, res=32'h0000_0010.
REQ-028 A=32'hDEAD_BEEF, B[10:6]=0 -> no busy, done high at cycle 1, res=32'hDEAD_BEEF.
REQ-029 A=32'hFFFF_FFFF, B[10:6]=31 -> done at cycle 32, res=32'h8000_0000; a start pulsed mid-shift is ignored and res is unchanged.
REQ-030 Two operations back-to-back:
- op 1: A=32'h0000_00FF, n=8 -> res=32'h0000_FF00;
- start held high in DONE, A=32'h1, n=1 -> res=32'h2 two cycles later, with no IDLE cycle in between.
REQ-031 Start A=32'h1, n=20; drop rst_n after 5 cycles -> busy=0, done=0 and res=0 immediately; no done pulse follows.
REQ-032 With SLL32_SEQ_VAR_EN defined: var_sel=1, B=32'h0000_0003 (B[10:6]=0), A=32'h1 -> res=32'h8 at cycle 4; var_sel=0 with the same inputs -> res=32'h1 at cycle 1.
